// File: rtl/mdr_mem_ctrl.sv
// MAR/MDR pair with a request/acknowledge memory handshake and an ack timeout.
// Bus loads only land in IDLE; a read ack writes the returned data into the MDR.
module mdr_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  MARin,
  input  logic                  MDRin,
  input  logic                  Read,
  input  logic                  mem_rd_start,
  input  logic                  mem_wr_start,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [DATA_WIDTH-1:0] BusMuxIn_MDR,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mar_q, mar_d;
  logic [DATA_WIDTH-1:0]   mdr_q, mdr_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (MARin) mar_d = BusMuxOut[ADDR_WIDTH-1:0];
        if (MDRin && !Read) mdr_d = BusMuxOut;
        // A write start takes priority; a simultaneous read is simply dropped.
        if (mem_rd_start || mem_wr_start) begin
          state_d = ACCESS;
          wr_d    = mem_wr_start;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = DONE;
          if (!wr_q) mdr_d = mem_rdata;
        end else if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered views of the next state.
    req_d  = (state_d == ACCESS);
    we_d   = req_d && wr_d;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign BusMuxIn_MDR = mdr_q;
  assign mem_wdata    = mdr_q;
  assign mem_addr     = mar_q;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Directed plus randomized bench for mdr_mem_ctrl; expectations come from a
// transaction-level model of MAR, MDR, err and the per-access ack delay.
module tb_mdr_mem_ctrl;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          clear_n = 1'b0;
  logic [DW-1:0] BusMuxOut = '0;
  logic          MARin = 1'b0;
  logic          MDRin = 1'b0;
  logic          Read = 1'b0;
  logic          mem_rd_start = 1'b0;
  logic          mem_wr_start = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] BusMuxIn_MDR;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_req;
  logic          mem_we;
  logic          busy;
  logic          done;
  logic          err;

  mdr_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .clear_n(clear_n), .BusMuxOut(BusMuxOut), .MARin(MARin),
    .MDRin(MDRin), .Read(Read), .mem_rd_start(mem_rd_start),
    .mem_wr_start(mem_wr_start), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .BusMuxIn_MDR(BusMuxIn_MDR), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int failures = 0;

  // Reference model: what the memory-side registers should hold.
  logic [AW-1:0] exp_mar = '0;
  logic [DW-1:0] exp_mdr = '0;
  logic          exp_err = 1'b0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    MARin = 1'b0; MDRin = 1'b0; Read = 1'b0;
    mem_rd_start = 1'b0; mem_wr_start = 1'b0; mem_ack = 1'b0;
    BusMuxOut = $urandom; mem_rdata = $urandom;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, ".mem_addr"}, DW'(mem_addr), DW'(exp_mar));
    checkOutput({tag, ".mdr"}, BusMuxIn_MDR, exp_mdr);
    checkOutput({tag, ".mem_wdata"}, mem_wdata, exp_mdr);
    checkBit({tag, ".err"}, err, exp_err);
  endtask

  task automatic checkIdle(input string tag);
    checkBit({tag, ".mem_req"}, mem_req, 1'b0);
    checkBit({tag, ".mem_we"}, mem_we, 1'b0);
    checkBit({tag, ".busy"}, busy, 1'b0);
    checkBit({tag, ".done"}, done, 1'b0);
    checkRegs(tag);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".BusMuxIn_MDR"}, BusMuxIn_MDR, '0);
    checkOutput({tag, ".mem_addr"}, DW'(mem_addr), '0);
    checkOutput({tag, ".mem_wdata"}, mem_wdata, '0);
    checkBit({tag, ".mem_req"}, mem_req, 1'b0);
    checkBit({tag, ".mem_we"}, mem_we, 1'b0);
    checkBit({tag, ".busy"}, busy, 1'b0);
    checkBit({tag, ".done"}, done, 1'b0);
    checkBit({tag, ".err"}, err, 1'b0);
  endtask

  // One IDLE-cycle edge with bus loads and optional starts; a stray ack rides along.
  task automatic applyStimulus(input logic marin, input logic mdrin, input logic rd_in,
                               input logic rd, input logic wr, input logic [DW-1:0] bus);
    MARin = marin; MDRin = mdrin; Read = rd_in; BusMuxOut = bus;
    mem_rd_start = rd; mem_wr_start = wr;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    tick();
    if (marin) exp_mar = bus[AW-1:0];
    if (mdrin && !rd_in) exp_mdr = bus;
    clearInputs();
  endtask

  // Full access: ack_at in 1..TO acks in that ACCESS cycle, anything else times out.
  task automatic runAccess(input string tag, input logic rd, input logic wr,
                           input logic marin, input logic mdrin, input logic rd_in,
                           input logic [DW-1:0] bus, input int ack_at,
                           input logic [DW-1:0] rdata);
    applyStimulus(marin, mdrin, rd_in, rd, wr, bus);
    exp_err = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      checkBit({tag, ".mem_req"}, mem_req, 1'b1);
      checkBit({tag, ".mem_we"}, mem_we, wr);
      checkBit({tag, ".busy"}, busy, 1'b1);
      checkBit({tag, ".done"}, done, 1'b0);
      checkRegs(tag);
      // Junk loads and starts while the access is in flight must be ignored.
      MARin = 1'($urandom); MDRin = 1'($urandom); Read = 1'($urandom);
      BusMuxOut = $urandom;
      mem_rd_start = 1'($urandom); mem_wr_start = 1'($urandom);
      mem_ack = (k == ack_at);
      mem_rdata = (k == ack_at) ? rdata : $urandom;
      tick();
      if (k == ack_at) begin
        if (!wr) exp_mdr = rdata;
        checkBit({tag, ".ack.done"}, done, 1'b1);
        checkBit({tag, ".ack.busy"}, busy, 1'b1);
        checkBit({tag, ".ack.mem_req"}, mem_req, 1'b0);
        checkBit({tag, ".ack.mem_we"}, mem_we, 1'b0);
        checkRegs({tag, ".ack"});
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
        tick();
        clearInputs();
        checkIdle({tag, ".after"});
        return;
      end
    end
    clearInputs();
    exp_err = 1'b1;
    checkIdle({tag, ".timeout"});
  endtask

  initial begin
    logic rd, wr;
    int   ack_at;

    // Reset held from time zero with junk on the inputs.
    BusMuxOut = $urandom; MARin = 1'b1; MDRin = 1'b1; mem_rd_start = 1'b1;
    mem_ack = 1'b1; mem_rdata = $urandom;
    #3;
    checkAllZero("reset_hold");
    @(negedge clock);
    clearInputs();
    clear_n = 1'b1;
    tick();
    checkIdle("post_reset");

    // Read: MAR<-0x012 in the start cycle, ack in the 2nd ACCESS cycle.
    runAccess("read", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0012, 2, 32'hDEAD_BEEF);

    // Write: preload MDR, then MAR<-0x1FF with the start, immediate ack.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
    checkIdle("mdr_load");
    runAccess("write", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_01FF, 1, 32'h0);

    // Timeout, recovery (err clears on start), and ack on the final count.
    runAccess("timeout", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 0, 32'h0);
    runAccess("recover", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 3, 32'hCAFE_F00D);
    runAccess("final_ack", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, TO, 32'h0BAD_F00D);

    // Both starts together: write only, with an MDR load in the same cycle.
    runAccess("both_starts", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h5A5A_00AA, 2, 32'hFFFF_FFFF);

    // Ack in IDLE changes nothing.
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    clearInputs();
    checkIdle("ack_idle");

    // Randomized accesses against the model.
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, $urandom);
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      ack_at = int'($urandom_range(0, TO + 1));
      runAccess("random", rd, wr, 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom, ack_at, $urandom);
    end

    // Asynchronous reset in the middle of an access.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0155);
    checkBit("abort.mem_req_before", mem_req, 1'b1);
    #3;
    clear_n = 1'b0;
    #1;
    checkAllZero("abort");
    exp_mar = '0; exp_mdr = '0; exp_err = 1'b0;
    #4;
    clear_n = 1'b1;
    tick();
    checkIdle("abort.after");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
